hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the 5-stage pipelined MIPS: drives stall/flush of the F/D/E/M pipeline
//  registers, forwarding selects for E and D, and bubble injection into the Memory/Writeback register.
//  Owns the data-memory handshake FSM: freezes the pipeline while a load/store in M waits on dmem_ready.
//  Keeps a sticky timeout flag and a saturating stall-cycle performance counter.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles in MEM_WAIT before mem_err sets (>=1)
//  CNT_WIDTH    32   width of stall_cnt
// PORTS
//  clk                    in   1   clock; all state on posedge
//  rst                    in   1   asynchronous, active-high reset
//  rsD, rtD               in   5   source regs in Decode
//  rsE, rtE               in   5   source regs in Execute
//  write_regE/M/W         in   5   destination reg per stage
//  RegWriteE/M/W          in   1   stage writes register file
//  MemtoRegE, MemtoRegM   in   1   stage holds a load
//  BranchD, PCSrcD        in   1   branch in Decode / branch taken
//  MemReadM, MemWriteM    in   1   memory op in M
//  dmem_ready             in   1   data memory completes op this cycle
//  dmem_req               out  1   = (MemReadM|MemWriteM), combinational
//  stallF, stallD         out  1   hold PC / F-D register
//  stallE, stallM         out  1   hold D-E / E-M register
//  flushD, flushE         out  1   clear F-D / D-E register
//  bubbleW                out  1   force RegWriteM=0 into Memory/Writeback
//  ForwardAE, ForwardBE   out  2   00 regfile, 01 W result, 10 M alu_result
//  ForwardAD, ForwardBD   out  1   1 = forward M alu_result to branch comparator
//  mem_err                out  1   sticky timeout flag
//  stall_cnt              out  CNT_WIDTH  cycles with stallF=1, saturating
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0; combinational outputs follow inputs.
//  memstall = dmem_req & ~dmem_ready (both states). FSM: RUN->MEM_WAIT on memstall; MEM_WAIT->RUN on dmem_ready.
//  wait_cnt: +1 per MEM_WAIT cycle, saturates at MEM_TIMEOUT, cleared in RUN; reaching MEM_TIMEOUT sets mem_err
//   (held until rst); FSM keeps waiting.
//  memstall priority: stallF=stallD=stallE=stallM=1, bubbleW=1, flushD=flushE=0; hazard stalls ignored.
//  Else lwstall = MemtoRegE & (rtE==rsD | rtE==rtD); branchstall = BranchD & ((RegWriteE & write_regE
//   in {rsD,rtD}) | (MemtoRegM & write_regM in {rsD,rtD})); stallF=stallD=flushE=lwstall|branchstall.
//  flushD = PCSrcD & ~stallD. stallE=stallM=bubbleW=0 outside memstall.
//  Forward E: M wins over W (RegWriteM & write_regM==rsE -> 10; else RegWriteW & match -> 01).
//  Forward D: RegWriteM & write_regM==rsD/rtD. Register $0 never forwarded and never causes stall.
//  W-stage RAW needs no stall (register file writes first half-cycle).
//  Stall outputs are combinational from current inputs; zero-cycle latency.
//  rst mid-wait: immediate return to RUN; dmem_req drops once M pipeline reg clears.
//  stall_cnt increments when stallF=1; holds at all-ones.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding as above.
//  Undefined: all Forward* = 0; D stalls on any RAW with RegWriteE or RegWriteM writer (non-$0),
//   flushE asserted with it; lwstall/branchstall subsumed.
// STRUCTURE
//  Shared package mips_hazard_defs: FWD_RF/FWD_WB/FWD_MEM encodings, FSM state encodings RUN/MEM_WAIT.
//  Sub-module hazard_mem_fsm: MEM_WAIT FSM, wait_cnt, mem_err; top holds detection, forwarding, stall_cnt.
// TESTING
//  lw $2 in E (rtE=2), rsD=2 -> stallF=stallD=flushE=1 one cycle; next cycle ForwardAE=01.
//  add $3 in M, rsE=3, same reg in W -> ForwardAE=10 (M priority); rsE=0 with write_regM=0 -> 00.
//  MemReadM=1, dmem_ready low 3 cycles -> all stalls+bubbleW high 3 cycles, FSM MEM_WAIT, stall_cnt +=3.
//  MEM_TIMEOUT=4, ready never -> mem_err=1 after 4th MEM_WAIT cycle, stays 1 after ready; clears on rst only.
//  BranchD, PCSrcD=1, no hazard -> flushD=1; with write_regE=rsD RegWriteE=1 -> stallD=1, flushD=0.
//  rst pulse during MEM_WAIT -> state RUN, wait_cnt=0, stall_cnt=0 immediately (async).

Source files
------------

// File: rtl/mips_hazard_defs.sv
// Shared encodings for the MIPS hazard controller: forwarding selects, memory-wait FSM states
// and the register-match helper used by both stall detection and forwarding.
package mips_hazard_defs;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    // $0 is hardwired to zero, so it never counts as a producer/consumer match
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory handshake FSM: tracks how long a load/store in M has been waiting and raises a
// sticky timeout flag once the wait reaches MEM_TIMEOUT cycles.
module hazard_mem_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic memstall,
    input  logic dmem_ready,
    output logic mem_err
);
    import mips_hazard_defs::*;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_VAL = WW'(MEM_TIMEOUT);

    logic [0:0]    state_reg;
    logic [WW-1:0] wait_cnt_reg;
    logic [WW-1:0] wait_cnt_next;
    logic          mem_err_reg;

    assign wait_cnt_next = (wait_cnt_reg == TO_VAL) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    assign mem_err       = mem_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    wait_cnt_reg <= '0;
                    if (memstall) state_reg <= MEM_WAIT;
                end
                default: begin
                    // the timeout only flags the problem; the pipeline keeps waiting
                    wait_cnt_reg <= wait_cnt_next;
                    if (wait_cnt_next == TO_VAL) mem_err_reg <= 1'b1;
                    if (dmem_ready) state_reg <= RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: stall/flush/bubble control, forwarding
// selects and stall-cycle counter. Define HAZARD_FWD_EN to enable forwarding paths.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic [4:0]           rsE,
    input  logic [4:0]           rtE,
    input  logic [4:0]           write_regE,
    input  logic [4:0]           write_regM,
    input  logic [4:0]           write_regW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 MemtoRegM,
    input  logic                 BranchD,
    input  logic                 PCSrcD,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 bubbleW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 ForwardAD,
    output logic                 ForwardBD,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    import mips_hazard_defs::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic       memstall;
    logic       lwstall;
    logic       branchstall;
    logic       raw_stall;
    logic       hz_stall;
    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    logic [1:0] fwd_e [2];
    logic       fwd_d [2];
    logic [CNT_WIDTH-1:0] stall_cnt_reg;

    assign dmem_req = MemReadM | MemWriteM;
    assign memstall = dmem_req & ~dmem_ready;

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;
    assign src_d[0] = rsD;
    assign src_d[1] = rtD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_e[gi] = (RegWriteM && reg_match(src_e[gi], write_regM)) ? FWD_MEM :
                               (RegWriteW && reg_match(src_e[gi], write_regW)) ? FWD_WB  : FWD_RF;
            assign fwd_d[gi] = RegWriteM && reg_match(src_d[gi], write_regM);
        end
    endgenerate

    assign lwstall = MemtoRegE & (reg_match(rtE, rsD) | reg_match(rtE, rtD));
    assign branchstall = BranchD &
        ((RegWriteE & (reg_match(write_regE, rsD) | reg_match(write_regE, rtD))) |
         (MemtoRegM & (reg_match(write_regM, rsD) | reg_match(write_regM, rtD))));

    // without forwarding, Decode must wait out every in-flight E/M producer it reads
    assign raw_stall =
        (RegWriteE & (reg_match(write_regE, rsD) | reg_match(write_regE, rtD))) |
        (RegWriteM & (reg_match(write_regM, rsD) | reg_match(write_regM, rtD)));

    assign hz_stall = FWD_EN ? (lwstall | branchstall) : (lwstall | branchstall | raw_stall);

    assign stallF  = memstall | hz_stall;
    assign stallD  = memstall | hz_stall;
    assign stallE  = memstall;
    assign stallM  = memstall;
    assign bubbleW = memstall;
    assign flushE  = ~memstall & hz_stall;
    assign flushD  = PCSrcD & ~stallD;

    assign ForwardAE = FWD_EN ? fwd_e[0] : FWD_RF;
    assign ForwardBE = FWD_EN ? fwd_e[1] : FWD_RF;
    assign ForwardAD = FWD_EN & fwd_d[0];
    assign ForwardBD = FWD_EN & fwd_d[1];

    hazard_mem_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_fsm (
        .clk       (clk),
        .rst       (rst),
        .memstall  (memstall),
        .dmem_ready(dmem_ready),
        .mem_err   (mem_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stallF && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected responses, a negedge monitor
// pops and compares them. Expectations follow the HAZARD_FWD_EN setting of the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // hazard bit order {stallF, stallD, stallE, stallM, flushD, flushE, bubbleW}
    localparam logic [6:0] H0  = 7'b0000000;
    localparam logic [6:0] HS  = 7'b1100010;
    localparam logic [6:0] HFD = 7'b0000100;
    localparam logic [6:0] HM  = 7'b1111001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
    logic [4:0] write_regE = '0, write_regM = '0, write_regW = '0;
    logic RegWriteE = 0, RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0, MemtoRegM = 0;
    logic BranchD = 0, PCSrcD = 0, MemReadM = 0, MemWriteM = 0, dmem_ready = 0;
    logic dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, bubbleW;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, mem_err;
    logic [3:0] stall_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .write_regE(write_regE), .write_regM(write_regM), .write_regW(write_regW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .bubbleW(bubbleW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
        .ForwardBD(ForwardBD), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] hz;
        logic [5:0] fwd;
        logic       req;
        logic       err;
        logic [3:0] cnt;
        int         id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int vec_id = 0;
    logic [3:0] exp_cnt = '0;

    function automatic logic [34:0] R(input int a, input int b, input int c, input int d,
                                      input int e, input int m, input int w);
        return {a[4:0], b[4:0], c[4:0], d[4:0], e[4:0], m[4:0], w[4:0]};
    endfunction

    // ctl order {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD, MemReadM, MemWriteM, dmem_ready}
    task automatic apply(input logic r, input logic [34:0] regs, input logic [9:0] ctl,
                         input logic [6:0] hz_f, input logic [6:0] hz_nf,
                         input logic [5:0] fwd_f, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW} = regs;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
         BranchD, PCSrcD, MemReadM, MemWriteM, dmem_ready} = ctl;
        e.hz  = FWD ? hz_f : hz_nf;
        e.fwd = FWD ? fwd_f : 6'b0;
        e.req = ctl[2] | ctl[1];
        e.err = err;
        if (r) exp_cnt = '0;
        e.cnt = exp_cnt;
        if (!r && e.hz[6] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        e.id = vec_id;
        vec_id++;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] hz_a;
            logic [5:0] fwd_a;
            e = q.pop_front();
            hz_a  = {stallF, stallD, stallE, stallM, flushD, flushE, bubbleW};
            fwd_a = {ForwardAE, ForwardBE, ForwardAD, ForwardBD};
            $display("vec %0d: hz=%b fwd=%b req=%b err=%b cnt=%0d", e.id, hz_a, fwd_a, dmem_req, mem_err, stall_cnt);
            checks++;
            if (hz_a !== e.hz) begin
                errors++;
                $display("FAIL vec %0d hazard: got %b expected %b", e.id, hz_a, e.hz);
            end
            checks++;
            if (fwd_a !== e.fwd) begin
                errors++;
                $display("FAIL vec %0d forward: got %b expected %b", e.id, fwd_a, e.fwd);
            end
            checks++;
            if ({dmem_req, mem_err} !== {e.req, e.err}) begin
                errors++;
                $display("FAIL vec %0d req/err: got %b%b expected %b%b", e.id, dmem_req, mem_err, e.req, e.err);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL vec %0d stall_cnt: got %0d expected %0d", e.id, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        // reset state
        apply(1, R(0,0,0,0,0,0,0), 10'b0000000000, H0, H0, 6'b000000, 0);
        // lw $2 in E, rsD=2
        apply(0, R(2,0,0,2,2,0,0), 10'b1001000000, HS, HS, 6'b000000, 0);
        // producer in W, rsE=2
        apply(0, R(0,0,2,0,0,0,2), 10'b0010000000, H0, H0, 6'b010000, 0);
        // same reg in M and W: M wins
        apply(0, R(0,0,3,3,0,3,3), 10'b0110000000, H0, H0, 6'b101000, 0);
        // $0 never forwarded
        apply(0, R(0,0,0,0,0,0,0), 10'b0110000000, H0, H0, 6'b000000, 0);
        // A from M, B from W, BD from M
        apply(0, R(5,4,4,5,0,4,5), 10'b0110000000, H0, HS, 6'b100101, 0);
        // taken branch, no hazard
        apply(0, R(1,2,0,0,0,0,0), 10'b0000011000, HFD, HFD, 6'b000000, 0);
        // taken branch with E writer of rsD
        apply(0, R(1,2,0,0,1,0,0), 10'b1000011000, HS, HS, 6'b000000, 0);
        // branch with load in M writing rtD
        apply(0, R(1,2,0,0,0,2,0), 10'b0100110000, HS, HS, 6'b000001, 0);
        // $0 everywhere: no stalls
        apply(0, R(0,0,0,0,0,0,0), 10'b1101110000, H0, H0, 6'b000000, 0);
        // ALU RAW from E: stall only without forwarding
        apply(0, R(7,0,0,0,7,0,0), 10'b1000000000, H0, HS, 6'b000000, 0);
        // load waits 3 cycles, hazards ignored
        for (int i = 0; i < 3; i++)
            apply(0, R(1,2,0,0,1,0,0), 10'b1000011100, HM, HM, 6'b000000, 0);
        apply(0, R(0,0,0,0,0,0,0), 10'b0000000101, H0, H0, 6'b000000, 0);
        apply(0, R(0,0,0,0,0,0,0), 10'b0000000000, H0, H0, 6'b000000, 0);
        // store never ready: mem_err after 4th MEM_WAIT cycle
        for (int i = 0; i < 6; i++)
            apply(0, R(0,0,0,0,0,0,0), 10'b0000000010, HM, HM, 6'b000000, (i == 5));
        apply(0, R(0,0,0,0,0,0,0), 10'b0000000011, H0, H0, 6'b000000, 1);
        apply(0, R(0,0,0,0,0,0,0), 10'b0000000000, H0, H0, 6'b000000, 1);
        // drive stall_cnt into saturation
        for (int i = 0; i < 4; i++)
            apply(0, R(2,0,0,2,2,0,0), 10'b1001000000, HS, HS, 6'b000000, 1);
        for (int i = 0; i < 2; i++)
            apply(0, R(0,0,0,0,0,0,0), 10'b0000000100, HM, HM, 6'b000000, 1);
        // async reset in the middle of MEM_WAIT
        apply(1, R(0,0,0,0,0,0,0), 10'b0000000000, H0, H0, 6'b000000, 0);
        for (int i = 0; i < 6; i++)
            apply(0, R(0,0,0,0,0,0,0), 10'b0000000100, HM, HM, 6'b000000, (i == 5));
        apply(0, R(0,0,0,0,0,0,0), 10'b0000000101, H0, H0, 6'b000000, 1);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
